param_counter: RTL and testbench
================================

# param_counter

Parametrised up/down counter for the FPGA emulation DUT set. It generalises the 8-bit start-value counter with configurable width, a programmable step and an explicit load strobe. Runtime limits bound the count, and three limit modes are available: wrap, saturate and one-shot. Terminal-count and sticky overflow/underflow flags let the emulation host observe limit events without polling every cycle.

## Interface
- WIDTH, 8, count/step/limit width in bits (≥2)
- RESET_VALUE, 0, count_out value after reset
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- enable  in  1  1 = advance count by step this cycle
- load  in  1  1 = load load_value this cycle
- load_value  in  WIDTH  value written on load
- inc_dec  in  1  0 = increment, 1 = decrement
- step  in  WIDTH  unsigned step size; 0 = hold
- limit_lo  in  WIDTH  lower bound, unsigned
- limit_hi  in  WIDTH  upper bound, unsigned
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- flag_clr  in  1  clears ovf and unf
- count_out  out  WIDTH  current count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky: an increment crossed limit_hi
- unf  out  1  sticky: a decrement crossed limit_lo
- running  out  1  1 = RUN state, 0 = HALT state

## Operation
- Reset values: count_out = RESET_VALUE, tc = 0, ovf = 0, unf = 0, state = RUN (running = 1).
- Priority per edge: aresetn low > load > enable advance.
- load: count_out <= load_value and state <= RUN. No tc, no flag set. Applies regardless of enable.
- State machine has two states:
  - RUN: an enabled step is evaluated.
  - HALT: count holds and enable is ignored.
  - RUN -> HALT only on a crossing in one-shot mode.
  - HALT -> RUN only on load or reset.
- Arithmetic is done in WIDTH+1 bits, unsigned.
  - Increment sum = count_out + step. It is a crossing if sum > limit_hi.
  - Decrement diff = count_out − step, signed in WIDTH+1 bits. It is a crossing if diff < limit_lo.
  - Landing exactly on a limit is not a crossing.
- With no crossing, count_out <= sum or diff, truncated to WIDTH bits.
- On a crossing (increment / decrement):
  - wrap: count_out <= limit_lo / limit_hi, tc = 1.
  - saturate: count_out <= limit_hi / limit_lo. tc = 1 only if count_out was not already equal to that limit.
  - one-shot: count_out <= limit_hi / limit_lo, tc = 1, state <= HALT.
- ovf sets on every increment crossing and unf on every decrement crossing, in all modes.
  - Each flag holds until flag_clr.
  - If a set and flag_clr occur in the same cycle, the set wins.
- step = 0 holds the count; no crossing is possible.
- Configuration error (limit_lo > limit_hi): count holds, tc = 0, flags unchanged. load still works.
- A count outside [limit_lo, limit_hi], after a load or a limit change, follows the same crossing rules as above.
- Limits, mode and step are sampled every cycle and are not latched.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on outputs after edge N.
- Latency from enable/load to count_out is 1 cycle.
- tc is high for exactly the cycle following the crossing edge.
- running falls on the same edge that applies the one-shot crossing value.
- Throughput is one step per cycle with enable held high.

## Test plan
- Reset: RESET_VALUE = 0, count at 37. Hold aresetn low 2 cycles with enable = 1 and load = 1 -> count_out = 0, tc/ovf/unf = 0, running = 1.
- Wrap increment: lo = 3, hi = 6, step = 1, load 3, then enable -> 4, 5, 6, 3, 4. tc pulses only with the first 3; ovf = 1 afterward.
- Saturate decrement: lo = 10, step = 4, load 17 -> 13, 10 (tc = 1, unf = 1), then 10 held with tc = 0 on later cycles.
- One-shot increment: hi = 200, step = 50, load 100 -> 150, 200, 200 (tc = 1, running = 0). Further enable leaves count at 200. Load 0 -> running = 1 and counting resumes from 0.
- Full range, wrap mode: lo = 0, hi = 255, step = 1.
  - Count 255 increments to 0 (ovf = 1). Count 0 decrements to 255 (unf = 1).
  - flag_clr asserted in the same cycle as a new crossing leaves the flag = 1.
  - flag_clr alone clears both flags.
- Priority and error cases:
  - load 9 with enable = 1 -> count_out = 9.
  - aresetn low mid-count -> count_out = RESET_VALUE the next cycle.
  - lo = 8, hi = 5 with enable -> count holds, tc = 0.

Source files
------------

// File: rtl/param_counter.sv
// param_counter: up/down counter with a programmable step, runtime limits and
// wrap / saturate / one-shot limit handling. It raises a one-cycle terminal-count
// pulse and sticky overflow/underflow flags. One-shot mode parks the counter in
// HALT until the next load or reset.
module param_counter #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc_dec,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit_lo,
    input  logic [WIDTH-1:0] limit_hi,
    input  logic [1:0]       mode,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             running
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // One extra bit on both operands: the carry of the sum and the borrow of
    // the difference both count as crossings.
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             inc_cross;
    logic             dec_cross;
    logic             cfg_err;
    logic             advance;

    // Evaluate both directions every cycle; the next-state logic picks one.
    always_comb begin
        sum_w     = {1'b0, count_q} + {1'b0, step};
        diff_w    = {1'b0, count_q} - {1'b0, step};
        inc_cross = sum_w > {1'b0, limit_hi};
        dec_cross = $signed(diff_w) < $signed({1'b0, limit_lo});
        cfg_err   = limit_lo > limit_hi;
        advance   = enable && (state_q == ST_RUN) && !cfg_err && (step != '0);
    end

    // Next-state logic: load has priority over an enabled step. HALT ignores enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~flag_clr;
        unf_d   = unf_q & ~flag_clr;

        if (load) begin
            count_d = load_value;
            state_d = ST_RUN;
        end else if (advance) begin
            if (!inc_dec) begin
                if (inc_cross) begin
                    ovf_d = 1'b1;
                    case (mode)
                        MODE_SAT: begin
                            count_d = limit_hi;
                            tc_d    = (count_q != limit_hi);
                        end
                        MODE_ONESHOT: begin
                            count_d = limit_hi;
                            tc_d    = 1'b1;
                            state_d = ST_HALT;
                        end
                        default: begin
                            count_d = limit_lo;
                            tc_d    = 1'b1;
                        end
                    endcase
                end else begin
                    count_d = sum_w[WIDTH-1:0];
                end
            end else begin
                if (dec_cross) begin
                    unf_d = 1'b1;
                    case (mode)
                        MODE_SAT: begin
                            count_d = limit_lo;
                            tc_d    = (count_q != limit_lo);
                        end
                        MODE_ONESHOT: begin
                            count_d = limit_lo;
                            tc_d    = 1'b1;
                            state_d = ST_HALT;
                        end
                        default: begin
                            count_d = limit_hi;
                            tc_d    = 1'b1;
                        end
                    endcase
                end else begin
                    count_d = diff_w[WIDTH-1:0];
                end
            end
        end
    end

    // State and output registers, with a synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_RUN;
            count_q <= RESET_VALUE;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_param_counter.sv
// Testbench for param_counter. Directed vectors cover the listed corner cases.
// A randomized phase then compares every output, every cycle, against an
// integer reference model.
module tb_param_counter;

    localparam int W = 8;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         enable;
    logic         load;
    logic [W-1:0] load_value;
    logic         inc_dec;
    logic [W-1:0] step;
    logic [W-1:0] limit_lo;
    logic [W-1:0] limit_hi;
    logic [1:0]   mode;
    logic         flag_clr;
    logic [W-1:0] count_out;
    logic         tc;
    logic         ovf;
    logic         unf;
    logic         running;

    param_counter #(.WIDTH(W), .RESET_VALUE(8'd0)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .inc_dec    (inc_dec),
        .step       (step),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .mode       (mode),
        .flag_clr   (flag_clr),
        .count_out  (count_out),
        .tc         (tc),
        .ovf        (ovf),
        .unf        (unf),
        .running    (running)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit     rstn;
        bit     en;
        bit     ld;
        int     ldv;
        bit     dec;
        int     stp;
        int     lo;
        int     hi;
        int     md;
        bit     clr;
    } in_t;

    typedef struct {
        in_t    i;
        int     cnt;
        bit     tc;
        bit     ovf;
        bit     unf;
        bit     run;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt;
    bit m_tc;
    bit m_ovf;
    bit m_unf;
    bit m_run;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Behavioural reference: applies the counting rules in plain integer arithmetic.
    task automatic model_step(input in_t s);
        int t;
        bit n_tc;
        bit n_ovf;
        bit n_unf;
        if (!s.rstn) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_run = 1;
            return;
        end
        n_tc  = 0;
        n_ovf = m_ovf && !s.clr;
        n_unf = m_unf && !s.clr;
        if (s.ld) begin
            m_cnt = s.ldv;
            m_run = 1;
        end else if (s.en && m_run && s.lo <= s.hi && s.stp != 0) begin
            t = s.dec ? m_cnt - s.stp : m_cnt + s.stp;
            if (!s.dec && t > s.hi) begin
                n_ovf = 1;
                if (s.md == 1)      begin n_tc = (m_cnt != s.hi); m_cnt = s.hi; end
                else if (s.md == 2) begin n_tc = 1; m_cnt = s.hi; m_run = 0; end
                else                begin n_tc = 1; m_cnt = s.lo; end
            end else if (s.dec && t < s.lo) begin
                n_unf = 1;
                if (s.md == 1)      begin n_tc = (m_cnt != s.lo); m_cnt = s.lo; end
                else if (s.md == 2) begin n_tc = 1; m_cnt = s.lo; m_run = 0; end
                else                begin n_tc = 1; m_cnt = s.hi; end
            end else begin
                m_cnt = t;
            end
        end
        m_tc  = n_tc;
        m_ovf = n_ovf;
        m_unf = n_unf;
    endtask

    // Drive one cycle's inputs, advance the model, and let the edge happen.
    task automatic apply(input in_t s);
        aresetn    = s.rstn;
        enable     = s.en;
        load       = s.ld;
        load_value = W'(s.ldv);
        inc_dec    = s.dec;
        step       = W'(s.stp);
        limit_lo   = W'(s.lo);
        limit_hi   = W'(s.hi);
        mode       = 2'(s.md);
        flag_clr   = s.clr;
        model_step(s);
        @(posedge aclk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic void addv(input bit rstn, input bit en, input bit ld, input int ldv,
                                 input bit dec, input int stp, input int lo, input int hi,
                                 input int md, input bit clr,
                                 input int cnt, input bit etc, input bit eovf,
                                 input bit eunf, input bit erun);
        vec_t v;
        v.i.rstn = rstn; v.i.en = en; v.i.ld = ld; v.i.ldv = ldv; v.i.dec = dec;
        v.i.stp = stp; v.i.lo = lo; v.i.hi = hi; v.i.md = md; v.i.clr = clr;
        v.cnt = cnt; v.tc = etc; v.ovf = eovf; v.unf = eunf; v.run = erun;
        vecs.push_back(v);
    endfunction

    initial begin
        //   rstn en ld ldv dec stp lo  hi  md clr | cnt tc ovf unf run
        // Reset while load and enable are active
        addv(0, 0, 0,  0, 0, 1,   0, 255, 0, 0,    0, 0, 0, 0, 1);
        addv(1, 0, 1, 37, 0, 1,   0, 255, 0, 0,   37, 0, 0, 0, 1);
        addv(0, 1, 1, 99, 0, 1,   0, 255, 0, 0,    0, 0, 0, 0, 1);
        addv(0, 1, 1, 99, 0, 1,   0, 255, 0, 0,    0, 0, 0, 0, 1);
        // Wrap increment in [3,6]
        addv(1, 0, 1,  3, 0, 1,   3,   6, 0, 0,    3, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   3,   6, 0, 0,    4, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   3,   6, 0, 0,    5, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   3,   6, 0, 0,    6, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   3,   6, 0, 0,    3, 1, 1, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   3,   6, 0, 0,    4, 0, 1, 0, 1);
        addv(1, 0, 0,  0, 0, 1,   3,   6, 0, 1,    4, 0, 0, 0, 1);
        // Saturate decrement with lo = 10
        addv(1, 0, 1, 17, 1, 4,  10, 255, 1, 0,   17, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 1, 4,  10, 255, 1, 0,   13, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 1, 4,  10, 255, 1, 0,   10, 1, 0, 1, 1);
        addv(1, 1, 0,  0, 1, 4,  10, 255, 1, 0,   10, 0, 0, 1, 1);
        addv(1, 1, 0,  0, 1, 4,  10, 255, 1, 0,   10, 0, 0, 1, 1);
        addv(1, 0, 0,  0, 1, 4,  10, 255, 1, 1,   10, 0, 0, 0, 1);
        // One-shot increment to hi = 200
        addv(1, 0, 1,100, 0, 50,  0, 200, 2, 0,  100, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 50,  0, 200, 2, 0,  150, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 50,  0, 200, 2, 0,  200, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 50,  0, 200, 2, 0,  200, 1, 1, 0, 0);
        addv(1, 1, 0,  0, 0, 50,  0, 200, 2, 0,  200, 0, 1, 0, 0);
        addv(1, 1, 1,  0, 0, 50,  0, 200, 2, 0,    0, 0, 1, 0, 1);
        addv(1, 1, 0,  0, 0, 50,  0, 200, 2, 0,   50, 0, 1, 0, 1);
        addv(1, 0, 0,  0, 0, 50,  0, 200, 2, 1,   50, 0, 0, 0, 1);
        // Full range wrap and flag_clr interplay
        addv(1, 0, 1,255, 0, 1,   0, 255, 0, 0,  255, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   0, 255, 0, 0,    0, 1, 1, 0, 1);
        addv(1, 1, 0,  0, 1, 1,   0, 255, 0, 0,  255, 1, 1, 1, 1);
        addv(1, 0, 0,  0, 0, 1,   0, 255, 0, 1,  255, 0, 0, 0, 1);
        addv(1, 0, 1,255, 0, 1,   0, 255, 0, 0,  255, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   0, 255, 0, 1,    0, 1, 1, 0, 1);
        addv(1, 0, 0,  0, 0, 1,   0, 255, 0, 1,    0, 0, 0, 0, 1);
        // Priority: load over enable, reset mid-count
        addv(1, 1, 1,  9, 0, 1,   0, 255, 0, 0,    9, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   0, 255, 0, 0,   10, 0, 0, 0, 1);
        addv(0, 1, 0,  0, 0, 1,   0, 255, 0, 0,    0, 0, 0, 0, 1);
        // Configuration error lo > hi: hold, but load works
        addv(1, 1, 0,  0, 0, 1,   8,   5, 0, 0,    0, 0, 0, 0, 1);
        addv(1, 0, 1,  7, 0, 1,   8,   5, 0, 0,    7, 0, 0, 0, 1);
        addv(1, 1, 0,  0, 0, 1,   8,   5, 0, 0,    7, 0, 0, 0, 1);
        // Out-of-range count, mode 11 acts as wrap, step 0 holds
        addv(1, 1, 0,  0, 0, 1,   3,   6, 3, 0,    3, 1, 1, 0, 1);
        addv(1, 1, 0,  0, 0, 0,   3,   6, 3, 0,    3, 0, 1, 0, 1);
        addv(1, 0, 1,  1, 1, 1,   3,   6, 0, 0,    1, 0, 1, 0, 1);
        addv(1, 1, 0,  0, 1, 1,   3,   6, 0, 0,    6, 1, 1, 1, 1);
        addv(1, 0, 0,  0, 1, 1,   3,   6, 0, 1,    6, 0, 0, 0, 1);

        foreach (vecs[k]) begin
            apply(vecs[k].i);
            $display("vec %0d: cnt=%0d tc=%0b ovf=%0b unf=%0b run=%0b", k,
                     count_out, tc, ovf, unf, running);
            chk("vec_count",   k, int'(count_out), vecs[k].cnt);
            chk("vec_tc",      k, int'(tc),        int'(vecs[k].tc));
            chk("vec_ovf",     k, int'(ovf),       int'(vecs[k].ovf));
            chk("vec_unf",     k, int'(unf),       int'(vecs[k].unf));
            chk("vec_running", k, int'(running),   int'(vecs[k].run));
        end

        // Randomized phase against the reference model
        for (int n = 0; n < 1500; n++) begin
            in_t s;
            s.rstn = ($urandom_range(0, 99) != 0);
            s.en   = ($urandom_range(0, 9) < 7);
            s.ld   = ($urandom_range(0, 9) == 0);
            s.ldv  = $urandom_range(0, 255);
            s.dec  = $urandom_range(0, 1) != 0;
            s.stp  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0) begin
                s.lo = $urandom_range(0, 127);
                s.hi = s.lo + $urandom_range(0, 128);
            end else begin
                s.lo = $urandom_range(0, 255);
                s.hi = $urandom_range(0, 255);
            end
            s.md  = $urandom_range(0, 3);
            s.clr = ($urandom_range(0, 9) == 0);
            apply(s);
            $display("rnd %0d: cnt=%0d tc=%0b ovf=%0b unf=%0b run=%0b", n,
                     count_out, tc, ovf, unf, running);
            chk("rnd_count",   n, int'(count_out), m_cnt);
            chk("rnd_tc",      n, int'(tc),        int'(m_tc));
            chk("rnd_ovf",     n, int'(ovf),       int'(m_ovf));
            chk("rnd_unf",     n, int'(unf),       int'(m_unf));
            chk("rnd_running", n, int'(running),   int'(m_run));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
